// File: rtl/safe_code_entry_if.sv
// ---------------------------------------------------------------------------
// safe_code_entry_if
//   Bundles the push-button inputs and display/status outputs of the safe
//   code-entry controller.
//
//   Signals:
//     key_inc, key_next, key_enter : synchronized button levels
//     digit_val    [2*NDIG-1:0]    : per-digit value, digit i = [2i+1:2i]
//     digit_en     [NDIG-1:0]      : per-digit flash enable
//     digit_interx [NDIG-1:0]      : per-digit one-cycle flash interrupt
//     unlocked                     : high while the safe is open
//     alarm                        : high while in lockout
//     tries_left   [1:0]           : remaining attempts
//
//   Modports:
//     master : drives the keys and observes the outputs (button front end / bench)
//     slave  : the controller itself
// ---------------------------------------------------------------------------
interface safe_code_entry_if #(
  parameter int NDIG = 4
);
  logic                 key_inc;
  logic                 key_next;
  logic                 key_enter;
  logic [2*NDIG-1:0]    digit_val;
  logic [NDIG-1:0]      digit_en;
  logic [NDIG-1:0]      digit_interx;
  logic                 unlocked;
  logic                 alarm;
  logic [1:0]           tries_left;

  modport master (
    output key_inc, key_next, key_enter,
    input  digit_val, digit_en, digit_interx, unlocked, alarm, tries_left
  );

  modport slave (
    input  key_inc, key_next, key_enter,
    output digit_val, digit_en, digit_interx, unlocked, alarm, tries_left
  );
endinterface

// File: rtl/safe_code_entry.sv
// ---------------------------------------------------------------------------
// safe_code_entry
//   Upstream controller for the safe's per-digit hex display stages. The user
//   dials NDIG 2-bit digits with the inc/next keys and submits with enter.
//   A matching code opens the safe; MAX_TRIES wrong codes cause a timed
//   lockout of LOCK_CYCLES clocks.
//
//   Ports:
//     clk   : system clock
//     reset : asynchronous reset, active low
//     bus   : safe_code_entry_if.slave (keys in; digit_val, digit_en,
//             digit_interx, unlocked, alarm, tries_left out)
//
//   Optional feature:
//     SAFE_CODE_ENTRY_AUTOCLEAR_EN - when defined, TIMEOUT_CYCLES clocks in
//     ENTRY without an accepted key edge clear the dialled digits.
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module safe_code_entry #(
  parameter int               NDIG        = 4,
  parameter logic [2*NDIG-1:0] COMBO      = 8'b10_01_11_00,
  parameter int               MAX_TRIES   = 3,
  parameter logic [15:0]      LOCK_CYCLES = 16'd4096
`ifdef SAFE_CODE_ENTRY_AUTOCLEAR_EN
  ,
  parameter logic [15:0]      TIMEOUT_CYCLES = 16'd50000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  safe_code_entry_if.slave    bus
);

  localparam int SEL_W = $clog2(NDIG);
  localparam logic [NDIG-1:0]  ONE_HOT0  = {{(NDIG-1){1'b0}}, 1'b1};
  localparam logic [NDIG-1:0]  ALL_ONES  = {NDIG{1'b1}};
  localparam logic [1:0]       TRIES_MAX = 2'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [SEL_W-1:0]    sel_q,      sel_d;
  logic [2*NDIG-1:0]   digits_q,   digits_d;
  logic [NDIG-1:0]     en_q,       en_d;
  logic [NDIG-1:0]     interx_q,   interx_d;
  logic                unlocked_q, unlocked_d;
  logic                alarm_q,    alarm_d;
  logic [1:0]          tries_q,    tries_d;
  logic [15:0]         lock_cnt_q, lock_cnt_d;
  logic                inc_q,  next_q,  enter_q;
`ifdef SAFE_CODE_ENTRY_AUTOCLEAR_EN
  logic [15:0]         idle_q,     idle_d;
`endif

  logic inc_rise, next_rise, enter_rise;
  logic [SEL_W-1:0] sel_inc;

  assign inc_rise   = bus.key_inc   & ~inc_q;
  assign next_rise  = bus.key_next  & ~next_q;
  assign enter_rise = bus.key_enter & ~enter_q;

  assign sel_inc = (sel_q == SEL_W'(NDIG-1)) ? '0 : sel_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    digits_d   = digits_q;
    en_d       = en_q;
    interx_d   = '0;
    unlocked_d = unlocked_q;
    alarm_d    = alarm_q;
    tries_d    = tries_q;
    lock_cnt_d = lock_cnt_q;
`ifdef SAFE_CODE_ENTRY_AUTOCLEAR_EN
    // Held at the reload value outside ENTRY, so entering ENTRY starts a
    // fresh idle period.
    idle_d     = TIMEOUT_CYCLES - 16'd1;
`endif

    unique case (state_q)
      ST_ENTRY: begin
        // Priority enter > next > inc; lower edges in the same cycle are dropped.
        if (enter_rise) begin
          if (digits_q == COMBO) begin
            state_d    = ST_OPEN;
            unlocked_d = 1'b1;
            tries_d    = TRIES_MAX;
            en_d       = '0;
            interx_d   = ALL_ONES;
          end else if (tries_q > 2'd1) begin
            tries_d  = tries_q - 2'd1;
            digits_d = '0;
            sel_d    = '0;
            en_d     = ONE_HOT0;
          end else begin
            state_d    = ST_LOCKOUT;
            tries_d    = 2'd0;
            alarm_d    = 1'b1;
            lock_cnt_d = LOCK_CYCLES - 16'd1;
            digits_d   = '0;
            sel_d      = '0;
            en_d       = ALL_ONES;
            interx_d   = ALL_ONES;
          end
        end else if (next_rise) begin
          // Interrupt the stage being left so it is not stuck blank.
          interx_d[sel_q] = 1'b1;
          sel_d           = sel_inc;
          en_d            = ONE_HOT0 << sel_inc;
        end else if (inc_rise) begin
          digits_d[2*sel_q +: 2] = digits_q[2*sel_q +: 2] + 2'd1;
          interx_d[sel_q]        = 1'b1;
        end
`ifdef SAFE_CODE_ENTRY_AUTOCLEAR_EN
        if (!(enter_rise || next_rise || inc_rise)) begin
          if (idle_q == 16'd0) begin
            digits_d = '0;
            sel_d    = '0;
            en_d     = ONE_HOT0;
            interx_d = ALL_ONES;
          end else begin
            idle_d = idle_q - 16'd1;
          end
        end
`endif
      end

      ST_OPEN: begin
        if (enter_rise) begin
          state_d    = ST_ENTRY;
          digits_d   = '0;
          sel_d      = '0;
          unlocked_d = 1'b0;
          tries_d    = TRIES_MAX;
          en_d       = ONE_HOT0;
          interx_d   = ALL_ONES;
        end
      end

      ST_LOCKOUT: begin
        if (lock_cnt_q == 16'd0) begin
          state_d  = ST_ENTRY;
          alarm_d  = 1'b0;
          tries_d  = TRIES_MAX;
          sel_d    = '0;
          en_d     = ONE_HOT0;
          interx_d = ALL_ONES;
        end else begin
          lock_cnt_d = lock_cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase

    // Back-to-back actions on one stage must not stretch its interrupt.
    interx_d = interx_d & ~interx_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ENTRY;
      sel_q      <= '0;
      digits_q   <= '0;
      en_q       <= ONE_HOT0;
      interx_q   <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      tries_q    <= TRIES_MAX;
      lock_cnt_q <= '0;
      // Key history resets high: a key held through reset release is not a press.
      inc_q      <= 1'b1;
      next_q     <= 1'b1;
      enter_q    <= 1'b1;
`ifdef SAFE_CODE_ENTRY_AUTOCLEAR_EN
      idle_q     <= TIMEOUT_CYCLES - 16'd1;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      digits_q   <= digits_d;
      en_q       <= en_d;
      interx_q   <= interx_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      tries_q    <= tries_d;
      lock_cnt_q <= lock_cnt_d;
      inc_q      <= bus.key_inc;
      next_q     <= bus.key_next;
      enter_q    <= bus.key_enter;
`ifdef SAFE_CODE_ENTRY_AUTOCLEAR_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign bus.digit_val    = digits_q;
  assign bus.digit_en     = en_q;
  assign bus.digit_interx = interx_q;
  assign bus.unlocked     = unlocked_q;
  assign bus.alarm        = alarm_q;
  assign bus.tries_left   = tries_q;

endmodule

// File: doc/safe_code_entry.md
Name: safe_code_entry

Overview:
- Upstream controller for the safe's per-digit hex display stages. Takes synchronized push-button levels and lets the user dial a multi-digit code of 2-bit digit values.
- Drives each display stage's ctrl, enable (flash) and interx (flash-interrupt) inputs.
- Compares the entered code against a fixed combination and reports unlocked/alarm, with an attempt limit and a timed lockout.

Parameters:
- NDIG, 4, number of code digits / display stages (2..8)
- COMBO, 8'b10_01_11_00, correct code; digit i = COMBO[2i+1:2i]; width 2*NDIG
- MAX_TRIES, 3, wrong entries allowed before lockout (1..3)
- LOCK_CYCLES, 16'd4096, lockout duration in clocks (>=1)
- TIMEOUT_CYCLES, 16'd50000, inactivity timeout; used only with the optional feature

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (0 = reset)
- key_inc  in  1  synchronized level: increment selected digit
- key_next  in  1  synchronized level: advance digit selection
- key_enter  in  1  synchronized level: submit / relock
- digit_val  out  2*NDIG  per-digit value to display ctrl; digit i = [2i+1:2i]
- digit_en  out  NDIG  per-digit flash enable
- digit_interx  out  NDIG  per-digit one-cycle flash interrupt
- unlocked  out  1  high while in OPEN
- alarm  out  1  high while in LOCKOUT
- tries_left  out  2  remaining attempts

Behaviour:
- All outputs are registered.
- Reset values:
  - state ENTRY, sel=0, digit_val=0, digit_en=one-hot bit 0, digit_interx=0
  - unlocked=0, alarm=0, tries_left=MAX_TRIES, lockout counter=0
  - key history registers=1, so a key held through reset release produces no action until it is released and pressed again.
- Edge detection: a press is key & ~key_q. The action is taken at the same clock edge that samples the rise and is visible on outputs after that edge (1-cycle latency). Holding a key gives exactly one action.
- Simultaneous edges: priority enter > next > inc. Lower-priority edges in the same cycle are discarded.
- ENTRY state (digit_en = one-hot of sel):
  - inc: digit[sel] <= digit[sel]+1 mod 4 (3 wraps to 0); digit_interx[sel] pulses for 1 cycle.
  - next: sel <= (sel+1) mod NDIG (NDIG-1 wraps to 0); digit_interx pulses on the old sel so that stage is not left blank.
  - enter with digits == COMBO: go to OPEN, unlocked=1, tries_left=MAX_TRIES.
  - enter with mismatch and tries_left>1: tries_left-1, all digits <= 0, sel <= 0, stay in ENTRY.
  - enter with mismatch and tries_left==1: tries_left=0, go to LOCKOUT, alarm=1, counter <= LOCK_CYCLES-1, digits <= 0.
- OPEN state (digit_en=0, digits hold the combination):
  - inc and next are ignored.
  - enter: go to ENTRY; digits <= 0, sel <= 0, unlocked <= 0, tries_left=MAX_TRIES.
- LOCKOUT state (digit_en = all ones, alarm=1):
  - All keys are ignored; key history is still tracked.
  - Counter decrements once per clock. In the cycle it reads 0: go to ENTRY, alarm <= 0, tries_left=MAX_TRIES, sel <= 0.
- On every transition out of a state, digit_interx pulses on all NDIG bits for 1 cycle so every display stage is forced out of blank.
- Reset asserted mid-operation: immediate return to reset values from any state, including mid-lockout.
- digit_interx is never high for more than 1 consecutive cycle on any bit.

Optional Feature:
- Macro SAFE_CODE_ENTRY_AUTOCLEAR_EN.
- Defined:
  - A 16-bit idle counter runs only in ENTRY and reloads on any accepted key edge or on entry to ENTRY.
  - After TIMEOUT_CYCLES clocks with no edge: digits <= 0, sel <= 0, digit_interx pulses on all bits.
  - tries_left is unchanged and the block stays in ENTRY.
- Undefined: no idle counter; digits hold indefinitely.

Test Plan:
1. Reset with key_inc held high, release reset, hold 5 cycles -> digit_val=0, no interx pulse; drop and re-raise key_inc -> digit 0 = 1 one cycle after the edge, digit_interx=4'b0001 for exactly 1 cycle.
2. Press inc 4 times on digit 0 -> value sequence 1,2,3,0 (wrap); press next 4 times -> digit_en 0010,0100,1000,0001 with interx on the old bit each time.
3. Dial 0,3,1,2 into digits 0..3 (digit_val=8'b10_01_11_00) then enter -> unlocked=1, digit_en=0, interx=4'b1111 one cycle; enter again -> unlocked=0, digit_val=0, tries_left=3.
4. Three wrong entries (all zeros) -> tries_left 2,1, then alarm=1, digit_en=1111; presses during lockout cause no change; after LOCK_CYCLES (bench override 8) -> alarm=0, tries_left=3.
5. key_enter and key_inc rise in the same cycle with wrong code -> digits are not incremented, tries_left decrements; reset pulsed low mid-lockout -> alarm=0 immediately (asynchronous), state ENTRY.
6. With SAFE_CODE_ENTRY_AUTOCLEAR_EN and TIMEOUT_CYCLES=10: set digit 0=2, idle 10 cycles -> digit_val=0, interx=1111, tries_left unchanged.
